// File: rtl/dsm2_mod_echip65.sv
`default_nettype none
// ============================================================================
// Module   : dsm2_mod_echip65
// Purpose  : Second-order digital sigma-delta modulator. Converts DW-bit
//            signed samples, delivered once every 2^OSR_LOG2 clocks, into a
//            1-bit stream at the clock rate. A 2-entry FIFO with a
//            valid/ready handshake decouples the sample producer from the
//            fixed load cadence.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DW            input sample width (two's complement)
//   OSR_LOG2      log2 of the oversampling ratio
// Ports
//   clk           modulator clock, rising edge
//   reset_n       synchronous active-low reset
//   in_data       signed input sample
//   in_valid      in_data is valid
//   in_ready      FIFO can accept a sample (0 while reset_n is low)
//   sample_strobe 1-cycle pulse when a sample enters the hold register
//   underrun      sticky flag, set when a load finds the FIFO empty
//   underrun_clr  clears underrun (a simultaneous set wins)
//   out           bitstream, 1 = +FS, 0 = -FS
// Build option
//   DSM_DITHER_EN defined: a 16-bit LFSR adds +/-1 LSB of dither to the
//                 loop input to break up idle tones.
// ============================================================================
module dsm2_mod_echip65 #(
  parameter int DW       = 14,
  parameter int OSR_LOG2 = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic signed [DW-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 sample_strobe,
  output logic                 underrun,
  input  logic                 underrun_clr,
  output logic                 out
);

  localparam int I1W = DW + 4;
  localparam int I2W = DW + 6;
  // Working width for the integrator sums: wide enough that i2 + i1 - 2*fb
  // cannot wrap before saturation is applied.
  localparam int EW  = I2W + 2;

  localparam logic signed [DW-1:0] CLAMP_HI = DW'(3 * (2 ** (DW - 3)));
  localparam logic signed [DW-1:0] CLAMP_LO = -CLAMP_HI;

  localparam logic signed [EW-1:0] FB_POS = EW'(2 ** (DW - 1));
  localparam logic signed [EW-1:0] FB_NEG = -FB_POS;

  localparam int I1_MAX_I = (2 ** (I1W - 1)) - 1;
  localparam int I2_MAX_I = (2 ** (I2W - 1)) - 1;
  localparam logic signed [EW-1:0] I1_MAX = EW'(I1_MAX_I);
  localparam logic signed [EW-1:0] I1_MIN = EW'(-I1_MAX_I - 1);
  localparam logic signed [EW-1:0] I2_MAX = EW'(I2_MAX_I);
  localparam logic signed [EW-1:0] I2_MIN = EW'(-I2_MAX_I - 1);

  localparam logic [OSR_LOG2-1:0] PHASE_LAST = {OSR_LOG2{1'b1}};
  localparam logic [OSR_LOG2-1:0] PHASE_ONE  = OSR_LOG2'(1);

  // --------------------------------------------------------------------------
  // Phase counter and load event
  // --------------------------------------------------------------------------
  logic [OSR_LOG2-1:0] phase;
  logic                load;

  assign load = (phase == PHASE_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase <= '0;
    end else begin
      phase <= phase + PHASE_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // 2-entry input FIFO
  // --------------------------------------------------------------------------
  logic signed [DW-1:0] fifo_mem [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           count;
  logic                 push;
  logic                 pop;
  logic                 empty_load;

  // Ready depends only on the registered count, gated by reset so nothing
  // is accepted while the block is held in reset.
  assign in_ready   = reset_n && (count != 2'd2);
  assign push       = in_valid && in_ready;
  // The pop decision uses the count before this cycle's push: a sample
  // arriving in the same cycle as an empty load does not bypass the FIFO.
  assign pop        = load && (count != 2'd0);
  assign empty_load = load && (count == 2'd0);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // --------------------------------------------------------------------------
  // Hold register, strobe and underrun flag
  // --------------------------------------------------------------------------
  logic signed [DW-1:0] x_hold;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x_hold        <= '0;
      sample_strobe <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      sample_strobe <= pop;
      if (pop) begin
        x_hold <= fifo_mem[rd_ptr];
      end
      if (empty_load) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Input clamp: keeps the second-order loop inside its stable input range
  // --------------------------------------------------------------------------
  logic signed [DW-1:0] xc;

  always_comb begin
    xc = x_hold;
    if (x_hold > CLAMP_HI) begin
      xc = CLAMP_HI;
    end else if (x_hold < CLAMP_LO) begin
      xc = CLAMP_LO;
    end
  end

  // --------------------------------------------------------------------------
  // Loop input, optionally dithered
  // --------------------------------------------------------------------------
  logic signed [EW-1:0] xe;

`ifdef DSM_DITHER_EN
  localparam logic signed [EW-1:0] DITHER_P = EW'(1);
  localparam logic signed [EW-1:0] DITHER_N = -DITHER_P;

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
  logic [15:0] lfsr;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr_fb, lfsr[15:1]};
    end
  end

  assign xe = EW'(xc) + (lfsr[0] ? DITHER_P : DITHER_N);
`else
  assign xe = EW'(xc);
`endif

  // --------------------------------------------------------------------------
  // Integrators and quantizer
  // --------------------------------------------------------------------------
  logic signed [I1W-1:0] i1;
  logic signed [I2W-1:0] i2;
  logic signed [EW-1:0]  fb;
  logic signed [EW-1:0]  sum1;
  logic signed [EW-1:0]  sum2;
  logic signed [I1W-1:0] i1_next;
  logic signed [I2W-1:0] i2_next;

  assign fb = out ? FB_POS : FB_NEG;

  always_comb begin
    sum1 = EW'(i1) + xe - fb;
    // i2 integrates the previous i1, giving the extra delay in the loop.
    sum2 = EW'(i2) + EW'(i1) - (fb <<< 1);

    if (sum1 > I1_MAX) begin
      i1_next = I1_MAX[I1W-1:0];
    end else if (sum1 < I1_MIN) begin
      i1_next = I1_MIN[I1W-1:0];
    end else begin
      i1_next = sum1[I1W-1:0];
    end

    if (sum2 > I2_MAX) begin
      i2_next = I2_MAX[I2W-1:0];
    end else if (sum2 < I2_MIN) begin
      i2_next = I2_MIN[I2W-1:0];
    end else begin
      i2_next = sum2[I2W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      i1  <= '0;
      i2  <= '0;
      out <= 1'b0;
    end else begin
      i1  <= i1_next;
      i2  <= i2_next;
      out <= ~i2_next[I2W-1];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dsm2_mod_echip65.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_dsm2_mod_echip65
// Purpose  : Self-checking bench for dsm2_mod_echip65. A behavioural model
//            (sample queue, integer integrators) predicts every output on
//            every cycle; stimulus is randomized with $urandom.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsm2_mod_echip65;

  localparam int DW       = 14;
  localparam int OSR_LOG2 = 8;
  localparam int OSR      = 1 << OSR_LOG2;
  localparam int FS       = 1 << (DW - 1);
  localparam int CLAMP    = 3 * (1 << (DW - 3));

  logic                 clk          = 1'b0;
  logic                 reset_n      = 1'b0;
  logic signed [DW-1:0] in_data      = '0;
  logic                 in_valid     = 1'b0;
  logic                 underrun_clr = 1'b0;
  logic                 in_ready;
  logic                 sample_strobe;
  logic                 underrun;
  logic                 out;

  dsm2_mod_echip65 #(
    .DW       (DW),
    .OSR_LOG2 (OSR_LOG2)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .sample_strobe (sample_strobe),
    .underrun      (underrun),
    .underrun_clr  (underrun_clr),
    .out           (out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  int q[$];
  int m_phase = 0;
  int m_hold  = 0;
  int m_i1    = 0;
  int m_i2    = 0;
  bit m_out   = 1'b0;
  bit m_strobe = 1'b0;
  bit m_under = 1'b0;
  int m_lfsr  = 16'hACE1;
  bit started = 1'b0;

  int  t_xc, t_xe, t_fb, t_n1, t_n2;
  bit  t_load, t_empty, t_ready;

  function automatic int sat(input int v, input int bits);
    int hi = (1 << (bits - 1)) - 1;
    int lo = -(1 << (bits - 1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  always @(posedge clk) begin
    started = 1'b1;
    if (!reset_n) begin
      q.delete();
      m_phase  = 0;
      m_hold   = 0;
      m_i1     = 0;
      m_i2     = 0;
      m_out    = 1'b0;
      m_strobe = 1'b0;
      m_under  = 1'b0;
      m_lfsr   = 16'hACE1;
    end else begin
      t_load  = (m_phase == OSR - 1);
      t_empty = (q.size() == 0);
      t_ready = (q.size() < 2);
      t_xc    = (m_hold > CLAMP) ? CLAMP : ((m_hold < -CLAMP) ? -CLAMP : m_hold);
`ifdef DSM_DITHER_EN
      t_xe    = t_xc + (((m_lfsr & 1) != 0) ? 1 : -1);
      m_lfsr  = (m_lfsr >> 1) |
                ((((m_lfsr >> 0) ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1) << 15);
`else
      t_xe    = t_xc;
`endif
      t_fb    = m_out ? FS : -FS;
      t_n1    = sat(m_i1 + t_xe - t_fb, DW + 4);
      t_n2    = sat(m_i2 + m_i1 - 2 * t_fb, DW + 6);
      m_i1    = t_n1;
      m_i2    = t_n2;
      m_out   = (t_n2 >= 0);
      m_strobe = t_load && !t_empty;
      if (t_load && !t_empty) m_hold = q.pop_front();
      if (t_load && t_empty) m_under = 1'b1;
      else if (underrun_clr) m_under = 1'b0;
      if (in_valid && t_ready) q.push_back(int'(in_data));
      m_phase = (m_phase + 1) % OSR;
    end
  end

  // Continuous comparison of every output against the model.
  always @(negedge clk) begin
    if (started) begin
      check_eq("out", out, m_out);
      check_eq("in_ready", in_ready, (reset_n && (q.size() < 2)));
      check_eq("sample_strobe", sample_strobe, m_strobe);
      check_eq("underrun", underrun, m_under);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_phase(input int target, input string tag);
    int n = 0;
    while (m_phase != target && n < 2 * OSR) begin
      step();
      n++;
    end
    check_eq(tag, m_phase, target);
  endtask

  task automatic run_const(input int v, input int windows, input int nominal,
                           input int tol, input string tag);
    int ones = 0;
    in_valid = 1'b1;
    in_data  = v[DW-1:0];
    for (int c = 0; c < windows * OSR; c++) begin
      step();
      if (c >= (windows - 1) * OSR) ones += int'(out);
    end
    if (tol >= 0) begin
      check_eq(tag, ((ones >= nominal - tol) && (ones <= nominal + tol)), 1);
    end
  endtask

  initial begin
    int xfers;
    int strobes;

    // Reset
    reset_n = 1'b0;
    repeat (3) step();
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out", out, 0);
    reset_n = 1'b1;
    #1;
    check_eq("rel_in_ready", in_ready, 1);

    // Levels: zero, +/-half scale, over-range (clamped)
    run_const(0,     6, 128, 2, "density_zero");
    run_const(4096,  8, 192, 3, "density_pos");
    run_const(-4096, 8, 64,  3, "density_neg");
    run_const(8191,  6, 224, -1, "clamp_pos");
    run_const(-8192, 4, 32,  -1, "clamp_neg");

    // Backpressure: continuous valid with distinct values
    in_valid = 1'b1;
    for (int c = 0; c < 2 * OSR; c++) begin
      in_data = DW'(($urandom_range(0, 8000)) - 4000);
      step();
    end
    xfers   = 0;
    strobes = 0;
    for (int c = 0; c < 4 * OSR; c++) begin
      if (in_valid && in_ready) xfers++;
      in_data = DW'(($urandom_range(0, 8000)) - 4000);
      step();
      strobes += int'(sample_strobe);
    end
    check_eq("bp_transfers", xfers, 4);
    check_eq("bp_strobes", strobes, 4);

    // Underrun: one more sample, then starve
    in_valid = 1'b0;
    repeat (3 * OSR) step();
    check_eq("underrun_set", underrun, 1);
    wait_phase(10, "wait_clr");
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    check_eq("underrun_clr", underrun, 0);
    wait_phase(OSR - 1, "wait_load");
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    check_eq("underrun_set_wins", underrun, 1);

    // Reset mid-stream with the FIFO full at phase 100
    in_valid = 1'b1;
    in_data  = DW'(1234);
    wait_phase(100, "wait_p100");
    check_eq("fifo_full", in_ready, 0);
    reset_n = 1'b0;
    step();
    check_eq("mid_rst_out", out, 0);
    check_eq("mid_rst_underrun", underrun, 0);
    reset_n = 1'b1;
    in_valid = 1'b0;
    #1;
    check_eq("mid_rst_in_ready", in_ready, 1);
    repeat (OSR + 4) step();

    // Randomized traffic
    for (int c = 0; c < 8 * OSR; c++) begin
      in_valid     = ($urandom_range(0, 99) < 60);
      in_data      = DW'($urandom());
      underrun_clr = ($urandom_range(0, 99) < 5);
      reset_n      = ($urandom_range(0, 999) != 0);
      step();
    end
    reset_n      = 1'b1;
    in_valid     = 1'b0;
    underrun_clr = 1'b0;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
